ti_sbox_layer_seq: RTL
======================

Name: ti_sbox_layer_seq

Overview:
- Sequences one full substitution layer of a masked cipher state through a single shared, pipelined threshold-implementation (TI) 4-bit S-box core. The core is external and built from the per-coordinate TI lookup functions, with a register between round 1 and round 2.
- Accepts the shared state over a valid/ready handshake, issues one nibble (all shares) per cycle to the core, and writes results back in place. It then presents the substituted shared state downstream.
- Sits between the cipher round datapath and the TI S-box core.

Parameters:
- NNIB, 16: number of 4-bit nibbles per share (state width per share = 4*NNIB).
- NSHARE, 4: number of Boolean shares.
- CORE_LAT, 2: fixed core latency in cycles from sb_in_valid to sb_res_valid.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  shared state is offered.
- in_ready  output  1  block can accept a state.
- in_state  input  4*NNIB*NSHARE  shared state. Share s occupies bits [4*NNIB*s +: 4*NNIB]; nibble i of share s occupies [4*NNIB*s+4*i +: 4].
- out_valid  output  1  substituted state is available.
- out_ready  input  1  downstream accepts the state.
- out_state  output  4*NNIB*NSHARE  substituted shared state, same layout as in_state.
- sb_in  output  4*NSHARE  nibble i of every share, concatenated with share 0 in the LSBs.
- sb_in_valid  output  1  sb_in carries a live nibble.
- sb_res  input  4*NSHARE  core output shares.
- sb_res_valid  input  1  core output is live.
- rnd_start  input  clog2(NNIB)  shuffle start index (used only with the optional feature).
- err  output  1  sticky protocol error.

Behaviour:
- States: IDLE, ISSUE, DRAIN, DONE.
- Reset values:
  - state = IDLE.
  - in_ready = 1 (registered).
  - out_valid = 0.
  - sb_in_valid = 0.
  - sb_in = 0.
  - err = 0.
  - out_state = 0.
  - issue counter = 0.
  - writeback index pipe = all zero, with all valid tags cleared.
- IDLE: in_ready = 1. On in_valid && in_ready, capture in_state into the state register, load issue counter = 0 and start index = 0, then go to ISSUE.
- ISSUE, one nibble per cycle for NNIB cycles:
  - index = (start + cnt) mod NNIB.
  - sb_in = that nibble (all shares); sb_in_valid = 1.
  - Push index and a valid tag into a CORE_LAT-deep tag shift register.
  - After cnt reaches NNIB-1, go to DRAIN.
  - in_ready = 0 in every state except IDLE.
- Writeback:
  - When a valid tag exits the tag pipe, the same cycle must carry sb_res_valid = 1.
  - sb_res is written into the state register at the tagged index, for all shares.
- DRAIN: wait until the tag pipe is empty and the last writeback has completed, then go to DONE. out_valid rises on the cycle after the final writeback.
- Latency: handshake accepted at cycle T → issues at T+1..T+NNIB → last writeback at T+NNIB+CORE_LAT → out_valid = 1 at T+NNIB+CORE_LAT+1. With defaults this is T+19.
- DONE: out_valid = 1 and out_state = state register, held stable until out_ready. On out_valid && out_ready, go to IDLE; in_ready returns to 1 on the next cycle (no same-cycle pass-through).
- Backpressure: the core has no stall. Issue never pauses once started.
- err (sticky until rst) sets when:
  - sb_res_valid = 1 while the exiting tag is invalid; or
  - the exiting tag is valid while sb_res_valid = 0.
  - Either way, the writeback still follows the tag, and the sequence completes normally.
- in_valid outside IDLE is ignored.
- Reset mid-operation: rst in any state returns everything to reset values on the next edge. Pending tags are dropped; late sb_res_valid pulses after reset set err only if they arrive after rst deasserts.
- Share separation:
  - sb_in carries exactly one nibble index per cycle.
  - sb_in is driven to 0 when sb_in_valid = 0, so no stale share data is left on the bus.

Optional Feature:
- Macro: TI_SHUFFLE_EN.
- Defined: on acceptance, start index = rnd_start sampled in the handshake cycle. Issue order is rnd_start, rnd_start+1, … with modulo-NNIB wrap. Every nibble is still processed exactly once.
- Undefined: start index is fixed at 0 and rnd_start is ignored. The port remains present so the block keeps one interface.

Test Plan:
- Basic layer: bench core is an identity model with 2-cycle latency. Accept a state with distinct share patterns → out_valid at exactly T+19, out_state == in_state, err = 0.
- S-box correctness: core model computes the unshared PRESENT S-box on share 0 and passes shares 1..3 through. Input share0 = 0x0123456789ABCDEF, other shares 0 → out share0 = 0xC56B90AD3EF84712.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid → out_state stable, in_ready = 0, a second in_valid is ignored. Raise out_ready → IDLE, in_ready = 1 on the next cycle.
- Protocol error: core model drops sb_res_valid for the nibble issued at T+5 → err = 1 from T+7, sequence still completes; err clears only on rst.
- Reset mid-issue: assert rst at T+8 → next cycle sb_in_valid = 0, in_ready = 1, out_valid = 0, err = 0. A fresh state then completes in 19 cycles.
- With TI_SHUFFLE_EN: rnd_start = 13 → sb_in indices 13,14,15,0,…,12; final out_state identical to the unshuffled run.

Source files
------------

// File: rtl/ti_sbox_layer_seq.sv
// Sequences one substitution layer of a shared cipher state through an external pipelined TI S-box core.
// Optional feature macro: TI_SHUFFLE_EN (issue order starts at rnd_start instead of nibble 0).
`timescale 1ns/1ps
module ti_sbox_layer_seq #(
    parameter int NNIB     = 16,
    parameter int NSHARE   = 4,
    parameter int CORE_LAT = 2,
    localparam int IW      = (NNIB > 1) ? $clog2(NNIB) : 1,
    localparam int SW      = 4 * NNIB,
    localparam int W       = SW * NSHARE,
    localparam int BW      = 4 * NSHARE
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_state,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_state,
    output logic [BW-1:0] sb_in,
    output logic          sb_in_valid,
    input  logic [BW-1:0] sb_res,
    input  logic          sb_res_valid,
    input  logic [IW-1:0] rnd_start,
    output logic          err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

    state_e        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          sb_in_valid_q;
    logic          err_q;
    logic [BW-1:0] sb_in_q;
    logic [IW-1:0] sb_idx_q;
    logic [IW-1:0] cnt_q;
    logic [IW-1:0] start_q;
    logic [W-1:0]  st_q;
    logic [CORE_LAT-1:0] tag_vld_q;
    logic [IW-1:0]       tag_idx_q [CORE_LAT];

    logic [IW-1:0] issue_idx_d;
    logic [IW-1:0] start_d;
    logic          wb_vld;
    logic [IW-1:0] wb_idx;
    logic          wb_pend;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
        logic [IW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (IW+1)'(NNIB)) sum = sum - (IW+1)'(NNIB);
        return sum[IW-1:0];
    endfunction

    function automatic logic [BW-1:0] nib_of(input logic [W-1:0] st, input logic [IW-1:0] idx);
        logic [BW-1:0] r;
        r = '0;
        for (int s = 0; s < NSHARE; s++) r[4*s +: 4] = st[SW*s + 4*int'(idx) +: 4];
        return r;
    endfunction

`ifdef TI_SHUFFLE_EN
    assign start_d = rnd_start;
`else
    logic unused_rnd;
    assign unused_rnd = ^rnd_start;
    assign start_d    = '0;
`endif

    assign issue_idx_d = wrap_add(start_q, cnt_q);
    assign wb_vld      = tag_vld_q[CORE_LAT-1];
    assign wb_idx      = tag_idx_q[CORE_LAT-1];

    // Anything still in flight other than the tag exiting this cycle keeps DRAIN waiting.
    always_comb begin
        wb_pend = sb_in_valid_q;
        for (int i = 0; i < CORE_LAT - 1; i++) wb_pend = wb_pend | tag_vld_q[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            sb_in_valid_q <= 1'b0;
            sb_in_q       <= '0;
            sb_idx_q      <= '0;
            err_q         <= 1'b0;
            cnt_q         <= '0;
            start_q       <= '0;
            st_q          <= '0;
            tag_vld_q     <= '0;
            for (int i = 0; i < CORE_LAT; i++) tag_idx_q[i] <= '0;
        end else begin
            // The tag pipe tracks sb_in one-for-one so it lines up with sb_res.
            tag_vld_q[0] <= sb_in_valid_q;
            tag_idx_q[0] <= sb_idx_q;
            for (int i = 1; i < CORE_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_idx_q[i] <= tag_idx_q[i-1];
            end

            if (wb_vld != sb_res_valid) err_q <= 1'b1;
            if (wb_vld) begin
                for (int s = 0; s < NSHARE; s++) st_q[SW*s + 4*int'(wb_idx) +: 4] <= sb_res[4*s +: 4];
            end

            sb_in_valid_q <= 1'b0;
            sb_in_q       <= '0;
            sb_idx_q      <= '0;

            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        st_q       <= in_state;
                        cnt_q      <= '0;
                        start_q    <= start_d;
                        in_ready_q <= 1'b0;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    sb_in_valid_q <= 1'b1;
                    sb_in_q       <= nib_of(st_q, issue_idx_d);
                    sb_idx_q      <= issue_idx_d;
                    cnt_q         <= cnt_q + 1'b1;
                    if (cnt_q == IW'(NNIB - 1)) state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!wb_pend) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_state   = st_q;
    assign sb_in       = sb_in_q;
    assign sb_in_valid = sb_in_valid_q;
    assign err         = err_q;

endmodule
